arith_cmd_requester: RTL and testbench

//  Initiator side of the arith_operations interface: accepts operation commands from the HPS/bus side

---
 rtl/arith_cmd_requester.sv | 130 +++++++++++++
 tb/tb_arith_cmd_requester.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_cmd_requester.sv
// arith_cmd_requester
//   Initiator for the arithmetic unit. Accepts one command at a time over a
//   valid/ready channel, drives registered operands into the unit, waits out
//   the unit's pipeline latency, captures C/rem and returns them over a
//   valid/ready response channel. Divide-by-zero is answered locally without
//   touching the unit operands.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_a, cmd_b, cmd_op         operands and op (00 add, 01 sub, 10 mul, 11 div)
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_rem          captured C / rem (all-ones / cmd_a on div0)
//   rsp_op, rsp_div0             op code of the response, divide-by-zero flag
//   au_a, au_b, au_sel           registered operands to the arithmetic unit
//   au_c, au_rem                 results from the arithmetic unit
//   busy                         not in IDLE
//   op_count                     completed responses, wraps
//
// State | Meaning
// IDLE  | ready for a command
// WAIT  | operands issued, counting down the unit latency
// CAPT  | unit output stable, capture it this edge
// RESP  | response held until the consumer takes it
module arith_cmd_requester #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 16,
  parameter int AU_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DIN_W-1:0]  cmd_a,
  input  logic [DIN_W-1:0]  cmd_b,
  input  logic [1:0]        cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DOUT_W-1:0] rsp_result,
  output logic [DIN_W-1:0]  rsp_rem,
  output logic [1:0]        rsp_op,
  output logic              rsp_div0,
  output logic [DIN_W-1:0]  au_a,
  output logic [DIN_W-1:0]  au_b,
  output logic [1:0]        au_sel,
  input  logic [DOUT_W-1:0] au_c,
  input  logic [DIN_W-1:0]  au_rem,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int WCW = (AU_LAT > 1) ? $clog2(AU_LAT) : 1;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           accept;
  logic           is_div0;

  // Ready and busy are pure decodes of the state register, so there is no
  // combinational path from cmd_valid to cmd_ready.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_div0   = (cmd_op == OP_DIV) && (cmd_b == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_rem    <= '0;
      rsp_op     <= '0;
      rsp_div0   <= 1'b0;
      au_a       <= '0;
      au_b       <= '0;
      au_sel     <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_op <= cmd_op;
            if (is_div0) begin
              // Answered locally; the unit keeps its previous operands.
              rsp_result <= '1;
              rsp_rem    <= cmd_a;
              rsp_div0   <= 1'b1;
              state      <= RESP;
            end else begin
              au_a     <= cmd_a;
              au_b     <= cmd_b;
              au_sel   <= cmd_op;
              rsp_div0 <= 1'b0;
              wait_cnt <= WCW'(AU_LAT - 1);
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPT;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        CAPT: begin
          rsp_result <= au_c;
          rsp_rem    <= au_rem;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // The div0 path arrives here with rsp_valid still low and raises
          // it one edge after accept.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_cmd_requester.sv
module tb_arith_cmd_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_rem;
  logic [1:0]  rsp_op;
  logic        rsp_div0;
  logic [7:0]  au_a;
  logic [7:0]  au_b;
  logic [1:0]  au_sel;
  logic [15:0] au_c = '0;
  logic [7:0]  au_rem = '0;
  logic        busy;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arith_cmd_requester #(.DIN_W(8), .DOUT_W(16), .AU_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_rem(rsp_rem), .rsp_op(rsp_op), .rsp_div0(rsp_div0),
    .au_a(au_a), .au_b(au_b), .au_sel(au_sel),
    .au_c(au_c), .au_rem(au_rem),
    .busy(busy), .op_count(op_count)
  );

  // Two-stage arithmetic unit model: operands registered on the first edge,
  // result registered on the second.
  logic [7:0] s_a = '0, s_b = '0;
  logic [1:0] s_sel = '0;
  always @(posedge clk) begin
    s_a   <= au_a;
    s_b   <= au_b;
    s_sel <= au_sel;
    case (s_sel)
      2'b00: begin au_c <= {8'd0, s_a} + {8'd0, s_b}; au_rem <= 8'd0; end
      2'b01: begin au_c <= {8'd0, s_a} - {8'd0, s_b}; au_rem <= 8'd0; end
      2'b10: begin au_c <= {8'd0, s_a} * {8'd0, s_b}; au_rem <= 8'd0; end
      default: begin
        au_c   <= (s_b != 0) ? {8'd0, s_a / s_b} : 16'd0;
        au_rem <= (s_b != 0) ? (s_a % s_b) : 8'd0;
      end
    endcase
  end

  // Drive a command at a negedge and let the next posedge accept it; returns
  // at the negedge after the accept edge with cmd_valid dropped.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts posedges from the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl: got ready/valid/busy=%b expected 100", {cmd_ready, rsp_valid, busy});
    end
    n_checks++;
    if ({au_a, au_b, au_sel, op_count} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got au_a=%0d au_b=%0d au_sel=%0d op_count=%0d expected all 0", au_a, au_b, au_sel, op_count);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int cyc;
    rsp_ready = 1'b1;
    issue(8'd200, 8'd100, 2'b00);
    n_checks++;
    if (!(busy === 1'b1 && cmd_ready === 1'b0 && au_a === 8'd200 && au_b === 8'd100 && au_sel === 2'b00)) begin
      n_fail++; $display("FAIL add_issue: got busy=%b ready=%b au=%0d,%0d,%0d expected 1,0,200,100,0", busy, cmd_ready, au_a, au_b, au_sel);
    end
    wait_rsp(cyc);
    n_checks++;
    if (cyc !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", cyc); end
    n_checks++;
    if (!(rsp_result === 16'd300 && rsp_rem === 8'd0 && rsp_div0 === 1'b0 && rsp_op === 2'b00)) begin
      n_fail++; $display("FAIL add_result: got result=%0d rem=%0d div0=%b op=%0d expected 300,0,0,0", rsp_result, rsp_rem, rsp_div0, rsp_op);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (!(rsp_valid === 1'b0 && op_count === 16'd1 && cmd_ready === 1'b1)) begin
      n_fail++; $display("FAIL add_handshake: got valid=%b op_count=%0d ready=%b expected 0,1,1", rsp_valid, op_count, cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int ready_err;
    rsp_ready = 1'b1;
    ready_err = 0;
    cmd_a = 8'd5; cmd_b = 8'd7; cmd_op = 2'b01; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    // Second command presented immediately and held.
    cmd_a = 8'd255; cmd_b = 8'd255; cmd_op = 2'b10;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      if (cmd_ready !== 1'b0) ready_err++;
      @(posedge clk); @(negedge clk); cyc++;
    end
    n_checks++;
    if (!(cyc === 3 && rsp_result === 16'hFFFE && rsp_op === 2'b01)) begin
      n_fail++; $display("FAIL sub_result: got lat=%0d result=%h op=%0d expected 3,fffe,1", cyc, rsp_result, rsp_op);
    end
    if (cmd_ready !== 1'b0) ready_err++;
    n_checks++;
    if (ready_err !== 0) begin n_fail++; $display("FAIL b2b_ready_early: got %0d ready cycles expected 0", ready_err); end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_after: got ready=%b valid=%b expected 1,0", cmd_ready, rsp_valid);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(cyc);
    n_checks++;
    if (!(cyc === 3 && rsp_result === 16'hFE01 && rsp_op === 2'b10)) begin
      n_fail++; $display("FAIL mul_result: got lat=%0d result=%h op=%0d expected 3,fe01,2", cyc, rsp_result, rsp_op);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (op_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", op_count); end
  endtask

  task automatic test_div_backpressure;
    int cyc;
    int hold_err;
    rsp_ready = 1'b0;
    hold_err = 0;
    issue(8'd200, 8'd7, 2'b11);
    wait_rsp(cyc);
    n_checks++;
    if (!(cyc === 3 && rsp_result === 16'd28 && rsp_rem === 8'd4 && rsp_div0 === 1'b0)) begin
      n_fail++; $display("FAIL div_result: got lat=%0d result=%0d rem=%0d div0=%b expected 3,28,4,0", cyc, rsp_result, rsp_rem, rsp_div0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_result === 16'd28 && rsp_rem === 8'd4 && cmd_ready === 1'b0)) hold_err++;
    end
    n_checks++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL div_hold: got %0d unstable cycles expected 0", hold_err); end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (!(rsp_valid === 1'b0 && op_count === 16'd4)) begin
      n_fail++; $display("FAIL div_handshake: got valid=%b op_count=%0d expected 0,4", rsp_valid, op_count);
    end
  endtask

  task automatic test_div0;
    int cyc;
    rsp_ready = 1'b1;
    issue(8'd9, 8'd0, 2'b11);
    wait_rsp(cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (!(rsp_div0 === 1'b1 && rsp_result === 16'hFFFF && rsp_rem === 8'd9 && rsp_op === 2'b11)) begin
      n_fail++; $display("FAIL div0_result: got div0=%b result=%h rem=%0d op=%0d expected 1,ffff,9,3", rsp_div0, rsp_result, rsp_rem, rsp_op);
    end
    n_checks++;
    if (!(au_a === 8'd200 && au_b === 8'd7 && au_sel === 2'b11)) begin
      n_fail++; $display("FAIL div0_au_hold: got au=%0d,%0d,%0d expected 200,7,3", au_a, au_b, au_sel);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (!(rsp_valid === 1'b0 && op_count === 16'd5)) begin
      n_fail++; $display("FAIL div0_handshake: got valid=%b op_count=%0d expected 0,5", rsp_valid, op_count);
    end
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    int stray;
    rsp_ready = 1'b1;
    stray = 0;
    issue(8'd3, 8'd4, 2'b10);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (!(au_a === 8'd0 && au_b === 8'd0 && au_sel === 2'b00 && op_count === 16'd0 && cmd_ready === 1'b1 && busy === 1'b0)) begin
      n_fail++; $display("FAIL midrst_state: got au=%0d,%0d,%0d count=%0d ready=%b busy=%b expected zeros, ready 1", au_a, au_b, au_sel, op_count, cmd_ready, busy);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) stray++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d valid cycles expected 0", stray); end
    issue(8'd1, 8'd1, 2'b00);
    wait_rsp(cyc);
    n_checks++;
    if (!(cyc === 3 && rsp_result === 16'd2)) begin
      n_fail++; $display("FAIL midrst_add: got lat=%0d result=%0d expected 3,2", cyc, rsp_result);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (op_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", op_count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_add;
    test_back_to_back;
    test_div_backpressure;
    test_div0;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
